// File: rtl/arith_pkg.sv
// Shared binary32 constants and field layout for the arith_* blocks.
package arith_pkg;

    localparam int unsigned FP_BIAS   = 127;
    localparam int unsigned FP_MANT_W = 23;
    localparam int unsigned FP_EXP_W  = 8;
    localparam int unsigned FP_W      = 32;

    // binary32 field layout, MSB first
    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp32_t;

endpackage

// File: rtl/arith_lzc.sv
// Leading-zero counter, purely combinational.
//   in_data : operand, W bits
//   count   : number of leading zeros; all-zero input yields W
module arith_lzc #(
    parameter int W = 32
) (
    input  logic [W-1:0]           in_data,
    output logic [$clog2(W+1)-1:0] count
);

    localparam int unsigned CW = $clog2(W+1);

    // Scan upward so the highest set bit decides the final count
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (in_data[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/arith_uitofp_pipe.sv
// Unsigned integer to IEEE-754 binary32 converter, 3-stage pipeline with
// valid/ready handshakes at both ends and bubble-collapsing stage enables.
//   clk, rst      : clock, synchronous active-high reset
//   a_valid/a_ready/a_data                 : operand handshake
//   result_valid/result_ready/result_data  : binary32 result handshake
// S1 registers the operand, S2 normalises (leading one removed), S3 rounds
// to nearest-even and packs.
module arith_uitofp_pipe
    import arith_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [IN_WIDTH-1:0]  a_data,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [OUT_WIDTH-1:0] result_data
);

    localparam int unsigned LZ_W = $clog2(IN_WIDTH + 1);
    // Working width: at least leading one + mantissa + guard
    localparam int unsigned NW   = (IN_WIDTH < 25) ? 25 : IN_WIDTH;
    localparam int unsigned SH_W = 7;
    // Fraction below the leading one is NW-1 bits; sticky covers the low NW-25
    localparam logic [NW-2:0] STICKY_MASK = {(NW-1){1'b1}} >> 24;

    // Elaboration-time parameter checks
    if (IN_WIDTH < 2 || IN_WIDTH > 64) begin : g_bad_in_width
        $fatal(1, "arith_uitofp_pipe: IN_WIDTH must be in 2..64");
    end
    if (OUT_WIDTH != 32) begin : g_bad_out_width
        $fatal(1, "arith_uitofp_pipe: OUT_WIDTH must be 32");
    end

    logic v1, v2, v3;
    logic en1, en2, en3;

    // Bubble-collapsing enables: a stage advances if empty or the next one moves
    assign en3          = !v3 | result_ready;
    assign en2          = !v2 | en3;
    assign en1          = !v1 | en2;
    assign a_ready      = en1;
    assign result_valid = v3;

    // ---------------- S1: operand register ----------------
    logic [IN_WIDTH-1:0] d1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (en1) begin
            v1 <= a_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (en1) begin
            d1 <= a_data;
        end
    end

    // ---------------- S2: leading-zero count and normalise ----------------
    logic [LZ_W-1:0]     lz_c;
    logic [SH_W-1:0]     shamt_c;
    logic [NW-1:0]       ext_c;
    logic [NW-2:0]       frac_c;
    logic [FP_EXP_W-1:0] exp_c;

    arith_lzc #(.W(IN_WIDTH)) u_lzc (
        .in_data (d1),
        .count   (lz_c)
    );

    // Shift the leading one to bit NW-1 and drop it; zero stays zero
    always_comb begin
        ext_c   = NW'(d1);
        shamt_c = SH_W'(lz_c) + SH_W'(NW - IN_WIDTH);
        frac_c  = (NW-1)'(ext_c << shamt_c);
        if (d1 == '0) begin
            exp_c = '0;
        end else begin
            exp_c = FP_EXP_W'(FP_BIAS + IN_WIDTH - 1) - FP_EXP_W'(lz_c);
        end
    end

    logic [NW-2:0]       frac2;
    logic [FP_EXP_W-1:0] exp2;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
        end else if (en2) begin
            v2 <= v1;
        end
    end

    always_ff @(posedge clk) begin
        if (en2) begin
            frac2 <= frac_c;
            exp2  <= exp_c;
        end
    end

    // ---------------- S3: round-to-nearest-even and pack ----------------
    logic [FP_MANT_W-1:0] mant_c;
    logic [FP_MANT_W-1:0] mant_r_c;
    logic                 guard_c;
    logic                 sticky_c;
    logic                 round_up_c;
    logic                 carry_c;
    fp32_t                packed_c;

    always_comb begin
        mant_c     = frac2[NW-2 -: FP_MANT_W];
        guard_c    = frac2[NW-25];
        sticky_c   = |(frac2 & STICKY_MASK);
        round_up_c = guard_c & (sticky_c | mant_c[0]);
        // Carry out means mantissa wrapped to zero; bump the exponent instead
        {carry_c, mant_r_c} = {1'b0, mant_c} + (FP_MANT_W+1)'(round_up_c);
        packed_c.sign = 1'b0;
        packed_c.exp  = exp2 + FP_EXP_W'(carry_c);
        packed_c.mant = mant_r_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3          <= 1'b0;
            result_data <= '0;
        end else if (en3) begin
            v3 <= v2;
            if (v2) begin
                result_data <= OUT_WIDTH'(packed_c);
            end
        end
    end

endmodule

// File: tb/tb_arith_uitofp_pipe.sv
// Self-checking bench for arith_uitofp_pipe: directed conversions, latency,
// back-pressure, mid-stream reset, a 64-bit instance and random traffic
// against an arithmetic reference conversion.
module tb_arith_uitofp_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result_data;

    logic        a_valid64;
    logic        a_ready64;
    logic [63:0] a_data64;
    logic        result_valid64;
    logic [31:0] result_data64;

    always #5 clk = ~clk;

    arith_uitofp_pipe #(.IN_WIDTH(32), .OUT_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_data       (a_data),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data)
    );

    arith_uitofp_pipe #(.IN_WIDTH(64), .OUT_WIDTH(32)) dut64 (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid64),
        .a_ready      (a_ready64),
        .a_data       (a_data64),
        .result_valid (result_valid64),
        .result_ready (1'b1),
        .result_data  (result_data64)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    int          acc_cyc_q[$];
    int          cyc = 0;
    logic        lat_on = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    logic        post_rst = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: value = q * 2^(k-23) with q rounded to nearest-even from the exact quotient
    function automatic logic [31:0] ref_cvt(input logic [63:0] x);
        int          k;
        int          sh;
        logic [63:0] q;
        logic [63:0] rem;
        logic [63:0] half;
        if (x == 64'd0) return 32'd0;
        k = 63;
        while (!x[k]) k--;
        if (k <= 23) begin
            q = x << (23 - k);
        end else begin
            sh   = k - 23;
            q    = x >> sh;
            rem  = x & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                k++;
            end
        end
        return {1'b0, 8'(127 + k), q[22:0]};
    endfunction

    // One clock cycle of 32-bit traffic; drive after negedge, check before posedge
    task automatic step(input logic av, input logic [31:0] ad, input logic [31:0] ex,
                        input logic rr, input logic r, output logic acc);
        @(negedge clk);
        a_valid      = av;
        a_data       = ad;
        result_ready = rr;
        rst          = r;
        acc          = 1'b0;
        #1;
        if (r) begin
            exp_q.delete();
            acc_cyc_q.delete();
            prev_hold = 1'b0;
            post_rst  = 1'b1;
        end else begin
            if (post_rst) begin
                chk("rst_valid", result_valid, 1'b0);
                chk("rst_data", result_data, 32'd0);
                post_rst = 1'b0;
            end
            chk("a_ready", a_ready, !(exp_q.size() == 3 && !rr));
            if (prev_hold) begin
                chk("hold_valid", result_valid, 1'b1);
                chk("hold_data", result_data, prev_data);
            end
            if (result_valid && rr) begin
                chk("no_spurious", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    chk("data", result_data, exp_q.pop_front());
                    if (lat_on) chk("latency", cyc - acc_cyc_q[0], 3);
                    void'(acc_cyc_q.pop_front());
                end
            end
            if (av && a_ready) begin
                acc = 1'b1;
                exp_q.push_back(ex);
                acc_cyc_q.push_back(cyc);
            end
            prev_hold = result_valid && !rr;
            prev_data = result_data;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic drain();
        logic acc;
        int   n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
            n++;
        end
        chk("drained", exp_q.size(), 0);
    endtask

    logic [31:0] bp_ops[5];
    logic [31:0] bp_exp[5];

    initial begin
        logic        acc;
        int          idx;
        int          n_out;
        logic        got;
        logic [63:0] x64;
        logic [31:0] x;
        logic [31:0] dir_ops[8];
        logic [31:0] dir_exp[8];

        a_valid = 1'b0; a_data = '0; result_ready = 1'b1; rst = 1'b1;
        a_valid64 = 1'b0; a_data64 = '0;

        // Reset state
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, acc);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, acc);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
        chk("reset_a_ready64", a_ready64, 1'b1);
        chk("reset_valid64", result_valid64, 1'b0);

        // Directed conversions with back-to-back issue and exact latency
        dir_ops = '{32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 32'h0100_0001,
                    32'h0100_0003, 32'hFFFF_FFFF, 32'h00FF_FFFF, 32'h0000_0003};
        dir_exp = '{32'h3F80_0000, 32'h0000_0000, 32'h4F00_0000, 32'h4B80_0000,
                    32'h4B80_0002, 32'h4F80_0000, 32'h4B7F_FFFF, 32'h4040_0000};
        lat_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, dir_ops[i], dir_exp[i], 1'b1, 1'b0, acc);
            chk("dir_accept", acc, 1'b1);
        end
        drain();

        // Back-pressure: result_ready low for 4 cycles mid-stream
        lat_on = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bp_ops[i] = $urandom;
            bp_exp[i] = ref_cvt(64'(bp_ops[i]));
        end
        idx = 0;
        n_out = 0;
        for (int c = 0; c < 16; c++) begin
            if (result_valid && !(c >= 3 && c < 7)) n_out++;
            step(idx < 5, (idx < 5) ? bp_ops[idx] : 32'd0, (idx < 5) ? bp_exp[idx] : 32'd0,
                 !(c >= 3 && c < 7), 1'b0, acc);
            if (acc) idx++;
        end
        chk("bp_all_sent", idx, 5);
        chk("bp_drained", exp_q.size(), 0);

        // Mid-stream reset with three operands in flight
        for (int i = 0; i < 3; i++) begin
            x = $urandom;
            step(1'b1, x, ref_cvt(64'(x)), 1'b1, 1'b0, acc);
        end
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, acc);
        lat_on = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
        step(1'b1, 32'h0000_0100, 32'h4380_0000, 1'b1, 1'b0, acc);
        drain();
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);

        // 64-bit instance: carry into exponent and top bit
        for (int i = 0; i < 6; i++) begin
            logic [31:0] ex64;
            case (i)
                0: begin x64 = 64'hFFFF_FFFF_FFFF_FFFF; ex64 = 32'h5F80_0000; end
                1: begin x64 = 64'h8000_0000_0000_0000; ex64 = 32'h5F00_0000; end
                default: begin
                    x64  = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63);
                    ex64 = ref_cvt(x64);
                end
            endcase
            @(negedge clk);
            a_valid64 = 1'b1;
            a_data64  = x64;
            #1;
            chk("a_ready64", a_ready64, 1'b1);
            got = 1'b0;
            for (int n = 0; n < 8 && !got; n++) begin
                @(negedge clk);
                a_valid64 = 1'b0;
                #1;
                if (result_valid64) begin
                    got = 1'b1;
                    chk("data64", result_data64, ex64);
                    chk("latency64", n, 2);
                end
            end
            chk("got64", got, 1'b1);
        end

        // Random traffic with random valid/ready
        lat_on = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            case ($urandom_range(0, 3))
                0:       x = $urandom_range(0, 255);
                1:       x = $urandom;
                default: x = $urandom >> $urandom_range(0, 31);
            endcase
            step($urandom_range(0, 3) != 0, x, ref_cvt(64'(x)),
                 $urandom_range(0, 3) != 0, 1'b0, acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
